bit_scan_seq: RTL
=================

# bit_scan_seq

Sequential bit-index decoder for the execution unit: the inverse of the bit-set operation. It takes an N-bit word and streams out, lowest first, the index of every set bit over a valid/ready handshake, then reports the population count and an error flag for an all-zero word. It sits beside the other ALU operation modules in the exe unit, behind the APB register front-end.

## Interface
- N, default 8: operand width in bits, N >= 2; IW = $clog2(N), CW = $clog2(N+1).
- clk  in  1  single clock, all state updated on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sampled in IDLE only; captures A and begins a scan.
- A  in  N  word to decode.
- busy  out  1  high in SCAN and DONE.
- idx  out  IW  index of current set bit; valid only with idx_valid.
- idx_valid  out  1  idx presented to consumer.
- idx_ready  in  1  consumer accepts idx.
- done  out  1  one-cycle pulse at end of scan.
- count  out  CW  number of indices accepted in the last scan; held until next start.
- error  out  1  set when the captured A was zero; held until next start.

## Operation
- Reset values: busy=0, idx=0, idx_valid=0, done=0, count=0, error=0; state IDLE, work=0, ptr=0.
- Asynchronous reset mid-scan aborts immediately; no partial done pulse; no indices are emitted after release until a new start.
- States: IDLE, SCAN, DONE.
- IDLE: on start, capture work=A, ptr=0, count=0, error=0. If A==0: error=1, go to DONE. Otherwise go to SCAN. A start while busy is ignored.
- SCAN: idx=ptr, idx_valid=work[ptr].
  - If work[ptr]=1 and idx_ready=1: clear work[ptr], count++, ptr++.
  - If work[ptr]=1 and idx_ready=0: hold; idx and idx_valid stay stable until accepted.
  - If work[ptr]=0: ptr++ with no output.
  - Go to DONE in the same edge that makes work zero.
- DONE: done=1 for exactly one cycle, then IDLE.
- ptr never wraps: work is zero before ptr passes N-1.
- count never exceeds N, so it fits in CW bits.
- idx_ready while idx_valid=0 has no effect.

## Timing
- Start is sampled at edge E0. SCAN is active in the first cycle after E0.
- Baseline throughput: one bit position per cycle, plus stall cycles while idx_ready=0.
- Scan latency with idx_ready tied high: (position of the highest set bit + 1) cycles in SCAN, then 1 cycle in DONE.
- A=0: done and error are high in the first cycle after E0.
- busy falls in the cycle after the done pulse; a new start is accepted in that cycle.

## Configuration
- BIT_SCAN_FAST_EN defined: in SCAN, ptr is loaded from a priority encoder giving the lowest set bit of work.
  - idx_valid=1 in every SCAN cycle.
  - Zero bits cost no cycles, so latency is (popcount) SCAN cycles + 1 DONE cycle.
- BIT_SCAN_FAST_EN undefined: linear one-bit-per-cycle scan as described above.
- Emitted index order, count, error and handshake rules are identical in both builds.

## Test plan
- A=8'h05, idx_ready=1, baseline: idx=0 valid in cycle 1, no output in cycle 2, idx=2 valid in cycle 3, done in cycle 4, count=2, error=0. With FAST_EN: idx 0 then 2 in cycles 1-2, done in cycle 3.
- A=8'h00: done and error=1 in cycle 1, count=0, idx_valid never asserted.
- A=8'hFF, idx_ready toggling 1,0,1,0…: indices 0..7 in order, each held stable through its stall cycle, count=8, single done pulse.
- A=8'h80, idx_ready=1: baseline emits idx=7 in cycle 8 and done in cycle 9; FAST_EN emits idx=7 in cycle 1 and done in cycle 2.
- Start pulsed during SCAN with a different A: ignored; the current scan completes unchanged.
- rst_n asserted while idx_valid=1 on A=8'h0C: all outputs 0 immediately; after release, no idx_valid and no done until the next start.

Source files
------------

// File: rtl/bit_scan_seq.sv
// bit_scan_seq: streams the indices of set bits in A, lowest first, then reports popcount and zero-word error; define BIT_SCAN_FAST_EN to skip clear bits with a priority encoder
module bit_scan_seq #(
  parameter int N = 8,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  A,
  output logic          busy,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          error
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] work, work_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [CW-1:0] count_r, count_nx;
  logic err_r, err_nx;
  logic hit, take;
`ifdef BIT_SCAN_FAST_EN
  function automatic logic [IW-1:0] lsb(input logic [N-1:0] v);
    lsb = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) lsb = IW'(i);
  endfunction
`endif
  assign hit = work[ptr];
  assign take = state == SCAN && hit && idx_ready;
  assign count = count_r;
  assign error = err_r;
  // state and scan datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      ptr     <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      work    <= work_nx;
      ptr     <= ptr_nx;
      count_r <= count_nx;
      err_r   <= err_nx;
    end
  // next state: capture on start, consume one position (or one set bit) per cycle
  always_comb begin
    state_nx = state;
    work_nx  = work;
    ptr_nx   = ptr;
    count_nx = count_r;
    err_nx   = err_r;
    case (state)
      IDLE: if (start) begin
        work_nx  = A;
        count_nx = '0;
        err_nx   = A == '0;
        state_nx = A == '0 ? DONE : SCAN;
`ifdef BIT_SCAN_FAST_EN
        ptr_nx   = lsb(A);
`else
        ptr_nx   = '0;
`endif
      end
      SCAN: begin
        if (take) begin
          work_nx[ptr] = 1'b0;
          count_nx     = count_r + 1'b1;
        end
        if (work_nx == '0) state_nx = DONE;
`ifdef BIT_SCAN_FAST_EN
        else ptr_nx = lsb(work_nx);
`else
        else if (take || !hit) ptr_nx = ptr + 1'b1;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end
  // outputs decoded from the current state only
  always_comb begin
    busy      = state != IDLE;
    idx_valid = state == SCAN && hit;
    idx       = state == SCAN ? ptr : '0;
    done      = state == DONE;
  end
endmodule
